// File: rtl/clk_rate_meter_pkg.sv
// Shared definitions for the clock-rate meter: state encoding, default sizing
// and the lock-counter helper.
package clk_rate_meter_pkg;

    localparam int C_WIDTH_DEF  = 8;
    localparam int C_STABLE_DEF = 2;
    localparam int MATCH_W      = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Saturating increment used for the consecutive-match counter.
    function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] v,
                                                   input logic [MATCH_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/clk_rate_meter_sync_edge_det.sv
// Two-flop synchronizer plus history flop; emits a one-cycle pulse on each
// synchronized rising edge of an asynchronous input.
module sync_edge_det (
    input  logic clk_in,
    input  logic reset,
    input  logic d_in,
    output logic rise_out
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_out = s2 & ~s3;

endmodule

// File: rtl/clk_rate_meter.sv
// Measures the period of an asynchronous pulse/clock signal in clk_in cycles,
// reporting each period, a lock flag once stable, and a timeout when edges stop.
module clk_rate_meter
    import clk_rate_meter_pkg::*;
#(
    parameter int C_WIDTH  = C_WIDTH_DEF,
    parameter int C_STABLE = C_STABLE_DEF
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               sig_in,
    output logic [C_WIDTH-1:0] period_out,
    output logic               valid,
    output logic               locked,
    output logic               timeout,
    output state_t             state_dbg
);

    localparam logic [C_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [C_WIDTH-1:0] CNT_ONE = C_WIDTH'(1);
    localparam logic [MATCH_W-1:0] STABLE  = MATCH_W'(C_STABLE);

    state_t               state, state_nxt;
    logic [C_WIDTH-1:0]   cnt, cnt_nxt;
    logic [C_WIDTH-1:0]   period_nxt;
    logic                 valid_nxt;
    logic                 locked_nxt;
    logic                 timeout_nxt;
    logic [MATCH_W-1:0]   match_cnt, match_nxt;
    logic                 first_meas, first_nxt;
    logic                 rise;

    sync_edge_det u_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .d_in     (sig_in),
        .rise_out (rise)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            period_out <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            match_cnt  <= '0;
            first_meas <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            period_out <= period_nxt;
            valid      <= valid_nxt;
            locked     <= locked_nxt;
            timeout    <= timeout_nxt;
            match_cnt  <= match_nxt;
            first_meas <= first_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        period_nxt  = period_out;
        valid_nxt   = 1'b0;
        locked_nxt  = locked;
        timeout_nxt = 1'b0;
        match_nxt   = match_cnt;
        first_nxt   = first_meas;
        case (state)
            ST_IDLE: begin
                // The first edge only arms the counter; no period is known yet.
                if (rise) begin
                    cnt_nxt   = CNT_ONE;
                    first_nxt = 1'b1;
                    state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    period_nxt = cnt;
                    valid_nxt  = 1'b1;
                    cnt_nxt    = CNT_ONE;
                    first_nxt  = 1'b0;
                    if (first_meas)
                        match_nxt = '0;
                    else if (cnt == period_out)
                        match_nxt = sat_inc(match_cnt, STABLE);
                    else
                        match_nxt = '0;
                    locked_nxt = (match_nxt >= STABLE);
                end else if (cnt == CNT_MAX) begin
                    // Counter would wrap: edges have stopped, drop back and re-arm.
                    timeout_nxt = 1'b1;
                    locked_nxt  = 1'b0;
                    match_nxt   = '0;
                    cnt_nxt     = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_clk_rate_meter.sv
// Directed bench for clk_rate_meter: stimulus pushes expected outputs into a
// queue, a monitor pops and compares whenever valid or timeout is presented.
module tb_clk_rate_meter;
    import clk_rate_meter_pkg::*;

    localparam int W = 10;  // {timeout, locked, period[7:0]}

    logic       clk = 1'b1;
    logic       reset;
    logic       sig_in;
    logic [7:0] period_out;
    logic       valid;
    logic       locked;
    logic       timeout;
    state_t     state_dbg;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // clock/reset block
    always #5 clk = ~clk;

    clk_rate_meter #(.C_WIDTH(8), .C_STABLE(2)) dut (
        .clk_in     (clk),
        .reset      (reset),
        .sig_in     (sig_in),
        .period_out (period_out),
        .valid      (valid),
        .locked     (locked),
        .timeout    (timeout),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    // driver tasks
    task automatic push(input bit to, input bit lk, input int per);
        exp_q.push_back({to, lk, 8'(per)});
    endtask

    task automatic phase(input int p, input int n);
        int hi;
        hi = p / 2;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < p; j++) begin
                @(negedge clk);
                sig_in = (j < hi);
            end
        end
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sig_in = 1'b0;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_period"},  int'(period_out), 0);
        check({tag, "_valid"},   int'(valid), 0);
        check({tag, "_locked"},  int'(locked), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
        check({tag, "_state"},   int'(state_dbg), int'(ST_IDLE));
    endtask

    // scoreboard monitor
    initial begin : monitor
        int cyc;
        int last_cyc;
        bit have_prev;
        logic [W-1:0] got;
        logic [W-1:0] expv;
        int gap;
        cyc = 0;
        last_cyc = 0;
        have_prev = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!reset) begin
                have_prev = 0;
                continue;
            end
            if (valid && timeout) check("valid_and_timeout", 1, 0);
            if (valid || timeout) begin
                got = {timeout, locked, period_out};
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'(got), -1);
                end else begin
                    expv = exp_q.pop_front();
                    check("scoreboard", int'(got), int'(expv));
                    if (have_prev) begin
                        gap = expv[9] ? 255 : int'(expv[7:0]);
                        check("event_spacing", cyc - last_cyc, gap);
                    end
                end
                if (timeout) begin
                    have_prev = 0;
                end else begin
                    have_prev = 1;
                    last_cyc = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset  = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);          // 25 ns
        reset = 1'b1;

        // period 2: lock on third measurement
        push(0, 0, 2); push(0, 0, 2); push(0, 1, 2);
        phase(2, 4);
        // period 10
        push(0, 1, 2); push(0, 0, 10); push(0, 0, 10); push(0, 1, 10);
        phase(10, 4);
        // lock at period 4
        push(0, 1, 10); push(0, 0, 4); push(0, 0, 4); push(0, 1, 4);
        phase(4, 4);
        // switch to period 6: lock drops, re-asserts two measurements later
        push(0, 1, 4); push(0, 0, 6); push(0, 0, 6); push(0, 1, 6);
        phase(6, 4);
        // relock at 4, then stop edges -> timeout keeps period 4
        push(0, 1, 6); push(0, 0, 4); push(0, 0, 4); push(0, 1, 4);
        push(1, 0, 4);
        phase(4, 4);
        hold_low(300);
        // restart: first edge only arms
        push(0, 0, 4); push(0, 0, 4);
        phase(4, 3);
        // reset mid-measurement
        hold_low(3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_cleared("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        hold_low(3);
        push(0, 0, 4); push(0, 0, 4);
        phase(4, 3);
        // period 255 measures, period 256 times out, final arm times out
        push(0, 1, 4); push(0, 0, 255); push(1, 0, 255); push(1, 0, 255);
        phase(255, 1);
        phase(256, 1);
        phase(4, 1);
        hold_low(300);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
